// File: rtl/axi_sram_slave_if.sv
// AXI3-style bus bundle between a master and the SRAM slave (AR/R/AW/W/B channels).
// Latency: none, wires only.
// Backpressure: carried by the valid/ready pairs of each channel.
interface axi_sram_slave_if;
   // read address channel
   logic [3:0]  axi_arid;
   logic [31:0] axi_araddr;
   logic [3:0]  axi_arlen;
   logic [2:0]  axi_arsize;
   logic [1:0]  axi_arburst;
   logic [2:0]  axi_arprot;
   logic        axi_arvalid;
   logic        axi_arready;
   // read data channel
   logic [3:0]  axi_rid;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rlast;
   logic        axi_rvalid;
   logic        axi_rready;
   // write address channel
   logic [3:0]  axi_awid;
   logic [31:0] axi_awaddr;
   logic [3:0]  axi_awlen;
   logic [2:0]  axi_awsize;
   logic [1:0]  axi_awburst;
   logic [2:0]  axi_awprot;
   logic        axi_awvalid;
   logic        axi_awready;
   // write data channel
   logic [3:0]  axi_wid;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wlast;
   logic        axi_wvalid;
   logic        axi_wready;
   // write response channel
   logic [3:0]  axi_bid;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready;

   modport slave (
      input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arprot, axi_arvalid,
      output axi_arready,
      output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
      input  axi_rready,
      input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awprot, axi_awvalid,
      output axi_awready,
      input  axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      output axi_wready,
      output axi_bid, axi_bresp, axi_bvalid,
      input  axi_bready
   );

   modport master (
      output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arprot, axi_arvalid,
      input  axi_arready,
      input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
      output axi_rready,
      output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awprot, axi_awvalid,
      input  axi_awready,
      output axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      input  axi_wready,
      input  axi_bid, axi_bresp, axi_bvalid,
      output axi_bready
   );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI slave over a 32-bit word SRAM with independent read and write burst engines.
// Latency: first read beat the cycle after AR is accepted, then one beat per cycle; B the cycle after the last W beat.
// Backpressure: R and B outputs hold steady while rready/bready are low; one burst in flight per direction.
module axi_sram_slave #(
   parameter int          MEM_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic             clk,
   input logic             rst,
   axi_sram_slave_if.slave bus
);

   localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [2:0] SIZE_WORD   = 3'b010;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Everything captured from an address handshake that the burst needs later.
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } burst_ctx_t;

   typedef enum logic {R_IDLE, R_BURST} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   // A WRAP burst is only legal for 2, 4, 8 or 16 beats; the reserved encoding is never legal.
   function automatic logic burst_err(input logic [3:0] len, input logic [1:0] burst);
      logic err;
      err = 1'b0;
      if (burst == BURST_RSVD) begin
         err = 1'b1;
      end else if (burst == BURST_WRAP) begin
         err = !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
      end
      return err;
   endfunction

   // Address of the following beat; illegal bursts fall back to incrementing.
   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                             input logic [1:0] burst);
      logic [31:0] mask;
      logic [31:0] nxt;
      mask = (({28'd0, len} + 32'd1) << 2) - 32'd1;
      if (burst == BURST_FIXED) begin
         nxt = addr;
      end else if ((burst == BURST_WRAP) && !burst_err(len, burst)) begin
         nxt = (addr & ~mask) | ((addr + 32'd4) & mask);
      end else begin
         nxt = addr + 32'd4;
      end
      return nxt;
   endfunction

   logic [31:0] mem [MEM_WORDS];

   // ---------------------------------------------------------------- read side
   r_state_t    r_state, r_state_nxt;
   burst_ctx_t  r_ctx;
   logic [3:0]  r_cnt;
   logic [31:0] r_off;
   logic [IDX_W-1:0] r_idx;
   logic        r_in_range, r_last, r_err, ar_hs, r_hs;
   logic [31:0] r_word;

   assign r_off      = r_ctx.addr - BASE_ADDR;
   assign r_in_range = {1'b0, r_off} < MEM_BYTES;
   assign r_idx      = r_off[IDX_W+1:2];
   assign r_word     = mem[r_idx];
   assign r_last     = (r_cnt == r_ctx.len);
   assign r_err      = !r_in_range || burst_err(r_ctx.len, r_ctx.burst) || (r_ctx.size != SIZE_WORD);
   assign ar_hs      = bus.axi_arvalid && bus.axi_arready;
   assign r_hs       = bus.axi_rvalid && bus.axi_rready && !rst;

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_state_nxt;
   end

   // Read FSM next state and R/AR channel outputs.
   always_comb begin
      r_state_nxt     = r_state;
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b0;
      bus.axi_rlast   = 1'b0;
      bus.axi_rdata   = '0;
      bus.axi_rresp   = RESP_OKAY;
      bus.axi_rid     = '0;
      case (r_state)
         R_IDLE: begin
            bus.axi_arready = !rst;
            if (bus.axi_arvalid && !rst) r_state_nxt = R_BURST;
         end
         R_BURST: begin
            bus.axi_rvalid = 1'b1;
            bus.axi_rlast  = r_last;
            bus.axi_rdata  = r_in_range ? r_word : '0;
            if (!rst) begin
               bus.axi_rid   = r_ctx.id;
               bus.axi_rresp = r_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (bus.axi_rready && r_last) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read burst context: latch on AR, step the beat counter and address on each R beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctx <= '0;
         r_cnt <= '0;
      end else if (ar_hs) begin
         r_ctx <= '{id: bus.axi_arid, addr: bus.axi_araddr, len: bus.axi_arlen,
                    size: bus.axi_arsize, burst: bus.axi_arburst};
         r_cnt <= '0;
      end else if (r_hs) begin
         r_cnt      <= r_cnt + 4'd1;
         r_ctx.addr <= next_addr(r_ctx.addr, r_ctx.len, r_ctx.burst);
      end
   end

   // ---------------------------------------------------------------- write side
   w_state_t    w_state, w_state_nxt;
   burst_ctx_t  w_ctx;
   logic [3:0]  w_cnt;
   logic        w_err;
   logic [31:0] w_off;
   logic [IDX_W-1:0] w_idx;
   logic        w_in_range, w_last, aw_hs, w_hs, w_beat_err, b_err;

   assign w_off      = w_ctx.addr - BASE_ADDR;
   assign w_in_range = {1'b0, w_off} < MEM_BYTES;
   assign w_idx      = w_off[IDX_W+1:2];
   assign w_last     = (w_cnt == w_ctx.len);
   assign aw_hs      = bus.axi_awvalid && bus.axi_awready;
   assign w_hs       = bus.axi_wvalid && bus.axi_wready && !rst;
   // A beat is bad if it misses the array or its wlast disagrees with the burst length.
   assign w_beat_err = !w_in_range || (bus.axi_wlast != w_last);
   assign b_err      = w_err || burst_err(w_ctx.len, w_ctx.burst) || (w_ctx.size != SIZE_WORD);

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (rst) w_state <= W_IDLE;
      else     w_state <= w_state_nxt;
   end

   // Write FSM next state and AW/W/B channel outputs.
   always_comb begin
      w_state_nxt     = w_state;
      bus.axi_awready = 1'b0;
      bus.axi_wready  = 1'b0;
      bus.axi_bvalid  = 1'b0;
      bus.axi_bid     = '0;
      bus.axi_bresp   = RESP_OKAY;
      case (w_state)
         W_IDLE: begin
            bus.axi_awready = !rst;
            if (bus.axi_awvalid && !rst) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            bus.axi_wready = 1'b1;
            if (bus.axi_wvalid && w_last) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            bus.axi_bvalid = 1'b1;
            if (!rst) begin
               bus.axi_bid   = w_ctx.id;
               bus.axi_bresp = b_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (bus.axi_bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Write burst context: latch on AW, accumulate errors and step address per W beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_ctx <= '0;
         w_cnt <= '0;
         w_err <= 1'b0;
      end else if (aw_hs) begin
         w_ctx <= '{id: bus.axi_awid, addr: bus.axi_awaddr, len: bus.axi_awlen,
                    size: bus.axi_awsize, burst: bus.axi_awburst};
         w_cnt <= '0;
         w_err <= 1'b0;
      end else if (w_hs) begin
         w_cnt      <= w_cnt + 4'd1;
         w_ctx.addr <= next_addr(w_ctx.addr, w_ctx.len, w_ctx.burst);
         w_err      <= w_err | w_beat_err;
      end
   end

   // Byte-masked array write; the array itself keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (w_hs && w_in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.axi_wstrb[i]) mem[w_idx][8*i +: 8] <= bus.axi_wdata[8*i +: 8];
         end
      end
   end

   // Protection and write-ID fields carry no meaning for this slave.
   logic unused_ok;
   assign unused_ok = ^{bus.axi_arprot, bus.axi_awprot, bus.axi_wid, r_off, w_off};

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axi_sram_slave_if bus ();

   axi_sram_slave dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ------------------------------------------------------------ reference model
   localparam logic [31:0] MODEL_BASE  = 32'h0;
   localparam logic [31:0] MODEL_BYTES = 32'd16384;

   typedef struct {
      logic [31:0] data;
      logic        known;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rexp_t;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;

   logic [31:0] mdl [int];
   rexp_t       rq[$];
   bexp_t       bq[$];
   logic [31:0] rcap[$];
   logic [1:0]  rrcap[$];
   logic        rlcap[$];
   bexp_t       bcap[$];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit model_berr(input logic [3:0] len, input logic [1:0] burst);
      if (burst == 2'b11) return 1'b1;
      if (burst == 2'b10) return !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
      return 1'b0;
   endfunction

   function automatic bit model_inrange(input logic [31:0] a);
      logic [31:0] off;
      off = a - MODEL_BASE;
      return off < MODEL_BYTES;
   endfunction

   // Byte address of beat i: wrapping bursts cycle within the aligned block of len+1 words.
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [3:0] len,
                                             input logic [1:0] burst, input int i);
      logic [31:0] total, lo;
      if (burst == 2'b00) return start;
      if (burst == 2'b10 && !model_berr(len, burst)) begin
         total = (32'(len) + 32'd1) * 32'd4;
         lo    = start - (start % total);
         return lo + ((start - lo + 32'(i) * 32'd4) % total);
      end
      return start + 32'(i) * 32'd4;
   endfunction

   task automatic push_read_exp(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                                input logic [1:0] burst, input logic [2:0] size);
      rexp_t e;
      logic [31:0] ba;
      int idx;
      for (int i = 0; i <= int'(len); i++) begin
         ba      = beat_addr(a, len, burst, i);
         idx     = int'((ba - MODEL_BASE) >> 2);
         e.id    = id;
         e.last  = (i == int'(len));
         e.resp  = (!model_inrange(ba) || model_berr(len, burst) || size != 3'b010) ? 2'b10 : 2'b00;
         e.known = !model_inrange(ba) || mdl.exists(idx);
         e.data  = (model_inrange(ba) && mdl.exists(idx)) ? mdl[idx] : 32'h0;
         rq.push_back(e);
      end
   endtask

   // ------------------------------------------------------------ compare process
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.axi_rvalid) begin
            chk("r_beat_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
               if (rq[0].known) chk("rdata", bus.axi_rdata, rq[0].data);
               chk("rresp", 32'(bus.axi_rresp), 32'(rq[0].resp));
               chk("rlast", 32'(bus.axi_rlast), 32'(rq[0].last));
               chk("rid", 32'(bus.axi_rid), 32'(rq[0].id));
               if (bus.axi_rready) begin
                  rcap.push_back(bus.axi_rdata);
                  rrcap.push_back(bus.axi_rresp);
                  rlcap.push_back(bus.axi_rlast);
                  void'(rq.pop_front());
               end
            end
         end
         if (bus.axi_bvalid) begin
            chk("b_resp_expected", 32'(bq.size() != 0), 32'd1);
            if (bq.size() != 0) begin
               chk("bid", 32'(bus.axi_bid), 32'(bq[0].id));
               chk("bresp", 32'(bus.axi_bresp), 32'(bq[0].resp));
               if (bus.axi_bready) begin
                  bcap.push_back('{id: bus.axi_bid, resp: bus.axi_bresp});
                  void'(bq.pop_front());
               end
            end
         end
      end
   end

   // ------------------------------------------------------------ stimulus tasks
   task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [1:0] burst, input logic [2:0] size, output int t);
      @(posedge clk); #1;
      bus.axi_arid = id; bus.axi_araddr = a; bus.axi_arlen = len;
      bus.axi_arburst = burst; bus.axi_arsize = size; bus.axi_arvalid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.axi_arready) break;
         @(posedge clk); #1;
      end
      chk("ar_accepted", 32'(bus.axi_arready), 32'd1);
      t = cyc;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int stall_beat);
      int  t, beats, stall, last_t;
      bit  first;
      push_read_exp(id, a, len, burst, size);
      rcap.delete(); rrcap.delete(); rlcap.delete();
      bus.axi_rready = 1'b1;
      send_ar(id, a, len, burst, size, t);
      beats = 0; stall = 0; first = 1'b1; last_t = 0;
      for (int k = 0; k < 100 && beats <= int'(len); k++) begin
         @(posedge clk); #1;
         bus.axi_arvalid = 1'b0;
         if (beats == stall_beat && stall < 3) begin
            bus.axi_rready = 1'b0;
            stall++;
         end else begin
            bus.axi_rready = 1'b1;
         end
         @(negedge clk);
         if (first) begin
            chk("rvalid_cycle_after_ar", 32'(bus.axi_rvalid), 32'd1);
            first = 1'b0;
         end
         if (bus.axi_rvalid && bus.axi_rready) begin
            beats++;
            last_t = cyc;
         end
      end
      chk("read_beat_count", 32'(beats), 32'(len) + 32'd1);
      if (stall_beat < 0) chk("read_last_beat_cycle", 32'(last_t - t), 32'(len) + 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("arready_after_burst", 32'(bus.axi_arready), 32'd1);
      chk("read_queue_drained", 32'(rq.size()), 32'd0);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int wlast_beat);
      bit          err;
      logic [31:0] ba, w;
      int          idx, i;
      err = model_berr(len, burst) || size != 3'b010 || wlast_beat != int'(len);
      for (int b = 0; b <= int'(len); b++) begin
         ba = beat_addr(a, len, burst, b);
         if (!model_inrange(ba)) begin
            err = 1'b1;
         end else begin
            idx = int'((ba - MODEL_BASE) >> 2);
            w   = mdl.exists(idx) ? mdl[idx] : 32'h0;
            for (int k = 0; k < 4; k++) if (ws[b][k]) w[8*k +: 8] = wd[b][8*k +: 8];
            mdl[idx] = w;
         end
      end
      bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
      bcap.delete();
      @(posedge clk); #1;
      bus.axi_awid = id; bus.axi_awaddr = a; bus.axi_awlen = len;
      bus.axi_awburst = burst; bus.axi_awsize = size; bus.axi_awvalid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.axi_awready) break;
         @(posedge clk); #1;
      end
      chk("aw_accepted", 32'(bus.axi_awready), 32'd1);
      @(posedge clk); #1;
      bus.axi_awvalid = 1'b0;
      i = 0;
      bus.axi_wvalid = 1'b1; bus.axi_wdata = wd[0]; bus.axi_wstrb = ws[0];
      bus.axi_wlast = (wlast_beat == 0);
      for (int k = 0; k < 100 && i <= int'(len); k++) begin
         @(negedge clk);
         if (bus.axi_wready) i++;
         @(posedge clk); #1;
         if (i > int'(len)) begin
            bus.axi_wvalid = 1'b0; bus.axi_wlast = 1'b0;
         end else begin
            bus.axi_wdata = wd[i]; bus.axi_wstrb = ws[i]; bus.axi_wlast = (i == wlast_beat);
         end
      end
      chk("write_beat_count", 32'(i), 32'(len) + 32'd1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.axi_bvalid) break;
         @(posedge clk); #1;
      end
      chk("bvalid_seen", 32'(bus.axi_bvalid), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic chk_rcap(input string nm, input int i, input logic [31:0] exp);
      chk(nm, (rcap.size() > i) ? rcap[i] : 32'hDEAD_BEEF, exp);
   endtask

   // ------------------------------------------------------------ directed sequence
   initial begin
      int t;
      bus.axi_arid = '0; bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arsize = 3'b010;
      bus.axi_arburst = 2'b01; bus.axi_arprot = '0; bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b0;
      bus.axi_awid = '0; bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awsize = 3'b010;
      bus.axi_awburst = 2'b01; bus.axi_awprot = '0; bus.axi_awvalid = 1'b0;
      bus.axi_wid = '0; bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wlast = 1'b0;
      bus.axi_wvalid = 1'b0; bus.axi_bready = 1'b1;
      for (int k = 0; k < 16; k++) begin wd[k] = 32'h0; ws[k] = 4'hF; end

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_arready", 32'(bus.axi_arready), 32'd0);
      chk("rst_awready", 32'(bus.axi_awready), 32'd0);
      chk("rst_wready", 32'(bus.axi_wready), 32'd0);
      chk("rst_rvalid", 32'(bus.axi_rvalid), 32'd0);
      chk("rst_bvalid", 32'(bus.axi_bvalid), 32'd0);
      chk("rst_rlast", 32'(bus.axi_rlast), 32'd0);
      chk("rst_ids_resps", 32'({bus.axi_rid, bus.axi_bid, bus.axi_rresp, bus.axi_bresp}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("arready_first_cycle", 32'(bus.axi_arready), 32'd1);
      chk("awready_first_cycle", 32'(bus.axi_awready), 32'd1);

      // 4-beat INCR write then readback
      wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
      do_write(4'd5, 32'h100, 4'd3, 2'b01, 3'b010, 3);
      chk("wr_incr_bid", 32'(bcap.size() > 0 ? bcap[0].id : 4'hF), 32'd5);
      chk("wr_incr_bresp", 32'(bcap.size() > 0 ? bcap[0].resp : 2'b11), 32'd0);
      do_read(4'd3, 32'h100, 4'd3, 2'b01, 3'b010, -1);
      chk_rcap("rd_incr_b0", 0, 32'h11);
      chk_rcap("rd_incr_b1", 1, 32'h22);
      chk_rcap("rd_incr_b2", 2, 32'h33);
      chk_rcap("rd_incr_b3", 3, 32'h44);
      chk("rd_incr_rlast_pattern", 32'(rlcap.size() == 4 ? {rlcap[0], rlcap[1], rlcap[2], rlcap[3]} : 4'hF), 32'h1);

      // WRAP read starting mid-block
      do_read(4'd7, 32'h108, 4'd3, 2'b10, 3'b010, -1);
      chk_rcap("rd_wrap_b0", 0, 32'h33);
      chk_rcap("rd_wrap_b1", 1, 32'h44);
      chk_rcap("rd_wrap_b2", 2, 32'h11);
      chk_rcap("rd_wrap_b3", 3, 32'h22);
      chk("rd_wrap_resp_or", 32'(rrcap.size() == 4 ? (rrcap[0] | rrcap[1] | rrcap[2] | rrcap[3]) : 2'b11), 32'd0);

      // byte strobes
      wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
      do_write(4'd1, 32'h100, 4'd0, 2'b01, 3'b010, 0);
      ws[0] = 4'hF;
      do_read(4'd1, 32'h100, 4'd0, 2'b01, 3'b010, -1);
      chk_rcap("rd_strobe", 0, 32'h00BB_00DD);

      // out of range read, misplaced wlast
      do_read(4'd2, 32'h4000, 4'd0, 2'b01, 3'b010, -1);
      chk_rcap("rd_oor_data", 0, 32'h0);
      chk("rd_oor_resp", 32'(rrcap.size() > 0 ? rrcap[0] : 2'b00), 32'h2);
      chk("rd_oor_last", 32'(rlcap.size() > 0 ? rlcap[0] : 1'b0), 32'd1);
      for (int k = 0; k < 4; k++) wd[k] = 32'h1000 + 32'(k);
      do_write(4'd9, 32'h200, 4'd3, 2'b01, 3'b010, 1);
      chk("wr_early_wlast_bresp", 32'(bcap.size() > 0 ? bcap[0].resp : 2'b00), 32'h2);

      // rready stall on beat 2
      do_read(4'd4, 32'h100, 4'd3, 2'b01, 3'b010, 1);
      chk_rcap("rd_stall_b1", 1, 32'h22);
      chk_rcap("rd_stall_b3", 3, 32'h44);

      // FIXED, reserved burst, bad size, illegal WRAP length
      do_read(4'd6, 32'h104, 4'd2, 2'b00, 3'b010, -1);
      chk_rcap("rd_fixed_b2", 2, 32'h22);
      do_read(4'd8, 32'h100, 4'd1, 2'b11, 3'b010, -1);
      chk("rd_rsvd_resp", 32'(rrcap.size() > 1 ? rrcap[1] : 2'b00), 32'h2);
      do_read(4'd8, 32'h108, 4'd0, 2'b01, 3'b001, -1);
      chk("rd_size_resp", 32'(rrcap.size() > 0 ? rrcap[0] : 2'b00), 32'h2);
      do_read(4'd10, 32'h200, 4'd2, 2'b10, 3'b010, -1);
      chk_rcap("rd_badwrap_b2", 2, 32'h1002);

      // reset during beat 2 of 4
      push_read_exp(4'd3, 32'h100, 4'd3, 2'b01, 3'b010);
      bus.axi_rready = 1'b1;
      send_ar(4'd3, 32'h100, 4'd3, 2'b01, 3'b010, t);
      @(posedge clk); #1;
      bus.axi_arvalid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      rq.delete();
      @(negedge clk);
      chk("arready_during_rst", 32'(bus.axi_arready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rvalid_after_rst_edge", 32'(bus.axi_rvalid), 32'd0);
      chk("rlast_after_rst_edge", 32'(bus.axi_rlast), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("arready_after_rst_release", 32'(bus.axi_arready), 32'd1);
      do_read(4'd3, 32'h100, 4'd1, 2'b01, 3'b010, -1);
      chk_rcap("rd_after_rst_b0", 0, 32'h00BB_00DD);

      repeat (3) @(negedge clk);
      chk("b_queue_drained", 32'(bq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1);
   end

endmodule
